// File: rtl/cvxif_result_buffer.sv
// In-order result FIFO between the coprocessor result stage and the CPU result port.
// Issue credits are tracked in reserved_q, so the coprocessor only issues when a slot is free.
module cvxif_result_buffer #(
    parameter int unsigned Depth     = 4,
    parameter int unsigned IdWidth   = 4,
    parameter int unsigned DataWidth = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         issue_fire_i,
    output logic                         issue_ready_o,
    input  logic                         in_valid_i,
    input  logic [IdWidth-1:0]           in_id_i,
    input  logic [DataWidth-1:0]         in_data_i,
    input  logic [4:0]                   in_rd_i,
    input  logic                         in_we_i,
    output logic                         x_result_valid_o,
    input  logic                         x_result_ready_i,
    output logic [IdWidth-1:0]           x_result_id_o,
    output logic [DataWidth-1:0]         x_result_data_o,
    output logic [4:0]                   x_result_rd_o,
    output logic                         x_result_we_o,
    output logic [$clog2(Depth+1)-1:0]   level_o,
    output logic                         overflow_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [IdWidth-1:0]   id_q   [Depth];
    logic [DataWidth-1:0] data_q [Depth];
    logic [4:0]           rd_q   [Depth];
    logic                 we_q   [Depth];

    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q, reserved_q;
    logic            overflow_q;

    logic valid_c, pop_c, push_c, issue_c, unpend_c;

    // Pointer advance with wrap at Depth-1 (Depth need not be a power of two).
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign valid_c       = !rst_i && (count_q != '0);
    assign pop_c         = valid_c && x_result_ready_i;
    assign push_c        = !rst_i && in_valid_i && ((count_q != CntW'(Depth)) || pop_c);
    assign issue_ready_o = !rst_i && (reserved_q < CntW'(Depth));
    assign issue_c       = issue_fire_i && issue_ready_o;
    assign unpend_c      = pop_c && (reserved_q != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            reserved_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_c) wptr_q <= ptr_inc(wptr_q);
            if (pop_c)  rptr_q <= ptr_inc(rptr_q);

            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase

            case ({issue_c, unpend_c})
                2'b10:   reserved_q <= reserved_q + CntW'(1);
                2'b01:   reserved_q <= reserved_q - CntW'(1);
                default: reserved_q <= reserved_q;
            endcase

            // Sticky: dropped result or issue attempted without a credit.
            if ((in_valid_i && !push_c) || (issue_fire_i && !issue_ready_o))
                overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_c) begin
            id_q[wptr_q]   <= in_id_i;
            data_q[wptr_q] <= in_data_i;
            rd_q[wptr_q]   <= in_rd_i;
            we_q[wptr_q]   <= in_we_i;
        end
    end

    assign x_result_valid_o = valid_c;
    assign x_result_id_o    = valid_c ? id_q[rptr_q]   : '0;
    assign x_result_data_o  = valid_c ? data_q[rptr_q] : '0;
    assign x_result_rd_o    = valid_c ? rd_q[rptr_q]   : '0;
    assign x_result_we_o    = valid_c ? we_q[rptr_q]   : 1'b0;
    assign level_o          = rst_i ? '0 : count_q;
    assign overflow_o       = !rst_i && overflow_q;

endmodule

// File: tb/tb_cvxif_result_buffer.sv
// Scoreboard bench for cvxif_result_buffer: stimulus queues expected results, a monitor checks pops.
module tb_cvxif_result_buffer;

    localparam int unsigned Depth     = 4;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned DataWidth = 64;

    typedef struct {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [4:0]           rd;
        logic                 we;
    } res_t;

    logic                        clk_i = 1'b0;
    logic                        rst_i = 1'b1;
    logic                        issue_fire_i = 1'b0;
    logic                        issue_ready_o;
    logic                        in_valid_i = 1'b0;
    logic [IdWidth-1:0]          in_id_i = '0;
    logic [DataWidth-1:0]        in_data_i = '0;
    logic [4:0]                  in_rd_i = '0;
    logic                        in_we_i = 1'b0;
    logic                        x_result_valid_o;
    logic                        x_result_ready_i = 1'b0;
    logic [IdWidth-1:0]          x_result_id_o;
    logic [DataWidth-1:0]        x_result_data_o;
    logic [4:0]                  x_result_rd_o;
    logic                        x_result_we_o;
    logic [$clog2(Depth+1)-1:0]  level_o;
    logic                        overflow_o;

    int   errors = 0;
    int   checks = 0;
    res_t exp_q[$];

    cvxif_result_buffer #(.Depth(Depth), .IdWidth(IdWidth), .DataWidth(DataWidth)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_fire_i(issue_fire_i), .issue_ready_o(issue_ready_o),
        .in_valid_i(in_valid_i), .in_id_i(in_id_i), .in_data_i(in_data_i),
        .in_rd_i(in_rd_i), .in_we_i(in_we_i),
        .x_result_valid_o(x_result_valid_o), .x_result_ready_i(x_result_ready_i),
        .x_result_id_o(x_result_id_o), .x_result_data_o(x_result_data_o),
        .x_result_rd_o(x_result_rd_o), .x_result_we_o(x_result_we_o),
        .level_o(level_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake seen mid-cycle completes at the next rising edge.
    always @(negedge clk_i) begin
        if (x_result_valid_o && x_result_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop_id", 64'(x_result_id_o), 64'hFFFF);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("pop_id",   64'(x_result_id_o),   64'(e.id));
                chk("pop_data", x_result_data_o,       e.data);
                chk("pop_rd",   64'(x_result_rd_o),   64'(e.rd));
                chk("pop_we",   64'(x_result_we_o),   64'(e.we));
            end
        end
    end

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_push(input int id);
        res_t e;
        e.id   = IdWidth'(id);
        e.data = 64'hC0DE_0000_0000_0000 | 64'(id * 17 + 1);
        e.rd   = 5'(id + 1);
        e.we   = id[0];
        in_valid_i = 1'b1;
        in_id_i    = e.id;
        in_data_i  = e.data;
        in_rd_i    = e.rd;
        in_we_i    = e.we;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        issue_fire_i = 1'b0;
        in_valid_i   = 1'b0;
    endtask

    // Serial issue then push for n results, ready held low.
    task automatic fill(input int base, input int n);
        x_result_ready_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            issue_fire_i = 1'b1;
            cycle();
            issue_fire_i = 1'b0;
            drive_push(base + i);
            cycle();
            in_valid_i = 1'b0;
        end
    endtask

    task automatic drain();
        int c;
        x_result_ready_i = 1'b1;
        c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            cycle();
            c++;
        end
        chk("drain_remaining", 64'(exp_q.size()), 64'd0);
        cycle();
        chk("drain_valid", 64'(x_result_valid_o), 64'd0);
        chk("drain_level", 64'(level_o), 64'd0);
    endtask

    initial begin
        // Reset
        cycle();
        cycle();
        chk("rst_valid", 64'(x_result_valid_o), 64'd0);
        chk("rst_issue_ready", 64'(issue_ready_o), 64'd0);
        chk("rst_level", 64'(level_o), 64'd0);
        rst_i = 1'b0;
        #1;
        chk("post_rst_issue_ready", 64'(issue_ready_o), 64'd1);
        chk("post_rst_overflow", 64'(overflow_o), 64'd0);

        // Single result
        x_result_ready_i = 1'b1;
        issue_fire_i = 1'b1;
        cycle();
        issue_fire_i = 1'b0;
        begin
            res_t e;
            e.id = 4'd3; e.data = 64'hDEADBEEF; e.rd = 5'd5; e.we = 1'b1;
            in_valid_i = 1'b1; in_id_i = e.id; in_data_i = e.data; in_rd_i = e.rd; in_we_i = e.we;
            exp_q.push_back(e);
        end
        cycle();
        in_valid_i = 1'b0;
        chk("single_valid", 64'(x_result_valid_o), 64'd1);
        chk("single_id", 64'(x_result_id_o), 64'd3);
        cycle();
        chk("single_level", 64'(level_o), 64'd0);
        chk("single_reserved", 64'(dut.reserved_q), 64'd0);
        chk("single_queue", 64'(exp_q.size()), 64'd0);

        // Backpressure fill
        fill(0, 3);
        chk("bp_ready_before_4th", 64'(issue_ready_o), 64'd1);
        fill(3, 1);
        chk("bp_ready_full", 64'(issue_ready_o), 64'd0);
        chk("bp_level_full", 64'(level_o), 64'd4);
        x_result_ready_i = 1'b1;
        cycle();
        chk("bp_ready_after_pop", 64'(issue_ready_o), 64'd1);
        chk("bp_level_after_pop", 64'(level_o), 64'd3);
        drain();

        // Simultaneous issue and pop at reserved=3, count=3
        fill(4, 3);
        x_result_ready_i = 1'b1;
        issue_fire_i = 1'b1;
        cycle();
        chk("sim_reserved", 64'(dut.reserved_q), 64'd3);
        chk("sim_level", 64'(level_o), 64'd2);
        x_result_ready_i = 1'b0;
        drive_push(7);
        cycle();
        issue_fire_i = 1'b0;
        chk("sim_level3", 64'(level_o), 64'd3);
        chk("sim_ready_full", 64'(issue_ready_o), 64'd0);
        x_result_ready_i = 1'b1;
        drive_push(8);
        cycle();
        in_valid_i = 1'b0;
        chk("sim_pushpop_level", 64'(level_o), 64'd3);
        chk("sim_pushpop_ready", 64'(issue_ready_o), 64'd1);
        drain();

        // Wrap-around with random ready
        begin
            int  issued;
            int  pid;
            bit  pend;
            issued = 0; pid = 0; pend = 1'b0;
            for (int c = 0; c < 400 && (issued < 11 || pend); c++) begin
                if (pend) drive_push(pid);
                else in_valid_i = 1'b0;
                issue_fire_i = (issued < 11) && issue_ready_o;
                if (issue_fire_i) begin
                    pid = issued;
                    issued++;
                end
                pend = issue_fire_i;
                x_result_ready_i = 1'($urandom_range(0, 1));
                cycle();
            end
            idle_inputs();
            chk("wrap_issued", 64'(issued), 64'd11);
        end
        drain();
        chk("wrap_overflow", 64'(overflow_o), 64'd0);

        // Overflow: push into full buffer is dropped
        fill(0, 4);
        drive_push(9);
        void'(exp_q.pop_back());
        cycle();
        in_valid_i = 1'b0;
        chk("ovf_flag", 64'(overflow_o), 64'd1);
        chk("ovf_level", 64'(level_o), 64'd4);
        chk("ovf_head_id", 64'(x_result_id_o), 64'd0);
        drain();
        chk("ovf_sticky", 64'(overflow_o), 64'd1);

        // Reset mid-operation
        fill(5, 2);
        rst_i = 1'b1;
        #1;
        chk("midrst_valid", 64'(x_result_valid_o), 64'd0);
        chk("midrst_issue_ready", 64'(issue_ready_o), 64'd0);
        exp_q.delete();
        cycle();
        rst_i = 1'b0;
        #1;
        chk("after_rst_valid", 64'(x_result_valid_o), 64'd0);
        chk("after_rst_level", 64'(level_o), 64'd0);
        chk("after_rst_overflow", 64'(overflow_o), 64'd0);
        chk("after_rst_issue_ready", 64'(issue_ready_o), 64'd1);
        x_result_ready_i = 1'b1;
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
